fp_add_arbiter: RTL and testbench

//   Round-robin arbiter sharing one pipelined IEEE-754 single-precision adder between NUM_REQ requesters.

---
 rtl/fp_add_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_fp_add_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one pipelined FP32 adder among NUM_REQ requesters, with a tag
// pipeline and credit-managed result FIFO. Define FPA_STATS_EN for grant/stall counters.
module fp_add_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADD_LAT    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clock_i,
    input  logic                       rst_n_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [32*NUM_REQ-1:0]      req_a_i,
    input  logic [32*NUM_REQ-1:0]      req_b_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic [31:0]                add_a_o,
    output logic [31:0]                add_b_o,
    input  logic [31:0]                add_sum_i,
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output logic [31:0]                res_data_o,
    output logic [$clog2(NUM_REQ)-1:0] res_id_o,
    input  logic                       flush_i,
    output logic                       flush_done_o
`ifdef FPA_STATS_EN
    ,
    output logic [16*NUM_REQ-1:0]      grant_cnt_o,
    output logic [15:0]                stall_cnt_o
`endif
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t               state_q, state_d;
    logic                 done_seen_q, done_seen_d;
    logic [IDW-1:0]       ptr_q, gnt_id;
    logic                 found, issue, credit;
    logic [NUM_REQ-1:0]   gnt;
    int                   idx;
    logic [31:0]          add_a_q, add_b_q;
    tag_t [ADD_LAT-1:0]   tag_q;
    logic [CW-1:0]        inflight, fifo_cnt_q;
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [IDW+31:0]      mem_q [FIFO_DEPTH];
    logic                 push, pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < ADD_LAT; i++) inflight = inflight + CW'(tag_q[i].vld);
    end

    // Counting in-flight tags as occupied slots guarantees every issued op has a FIFO entry.
    assign credit = (int'(fifo_cnt_q) + int'(inflight)) < FIFO_DEPTH;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr_q) + k) % NUM_REQ;
            if (!found && req_valid_i[idx]) begin
                found  = 1'b1;
                gnt_id = IDW'(idx);
            end
        end
        issue = found && (state_q == RUN) && credit;
        if (issue) gnt[gnt_id] = 1'b1;
    end

    // Gated by reset so no accept is advertised while the block is held in reset.
    assign req_ready_o = gnt & {NUM_REQ{rst_n_i}};
    assign add_a_o     = add_a_q;
    assign add_b_o     = add_b_q;

    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            add_a_q <= '0;
            add_b_q <= '0;
            ptr_q   <= IDW'(NUM_REQ - 1);
            tag_q   <= '0;
        end else begin
            if (issue) begin
                add_a_q <= req_a_i[32*gnt_id +: 32];
                add_b_q <= req_b_i[32*gnt_id +: 32];
                ptr_q   <= gnt_id;
            end
            tag_q[0] <= '{vld: issue, id: gnt_id};
            for (int i = 1; i < ADD_LAT; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    assign push        = tag_q[ADD_LAT-1].vld;
    assign res_valid_o = (fifo_cnt_q != '0);
    assign pop         = res_valid_o && res_ready_i;
    assign res_data_o  = res_valid_o ? mem_q[rd_ptr_q][31:0] : '0;
    assign res_id_o    = res_valid_o ? mem_q[rd_ptr_q][IDW+31:32] : '0;

    always_ff @(posedge clock_i) begin
        if (push) mem_q[wr_ptr_q] <= {tag_q[ADD_LAT-1].id, add_sum_i};
    end

    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 1'b1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 1'b1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= RUN;
            done_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            done_seen_q <= done_seen_d;
        end
    end

    // done_seen keeps a held flush parked in DRAIN without re-pulsing flush_done.
    always_comb begin
        state_d      = state_q;
        done_seen_d  = done_seen_q;
        flush_done_o = 1'b0;
        case (state_q)
            RUN: if (flush_i) state_d = DRAIN;
            DRAIN: begin
                if (done_seen_q) begin
                    if (!flush_i) begin
                        state_d     = RUN;
                        done_seen_d = 1'b0;
                    end
                end else if (inflight == '0 && fifo_cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                flush_done_o = 1'b1;
                done_seen_d  = flush_i;
                state_d      = flush_i ? DRAIN : RUN;
            end
            default: state_d = RUN;
        endcase
    end

`ifdef FPA_STATS_EN
    logic [NUM_REQ-1:0][15:0] gcnt_q;
    logic [15:0]              scnt_q;

    always_ff @(posedge clock_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            gcnt_q <= '0;
            scnt_q <= '0;
        end else begin
            if (issue && gcnt_q[gnt_id] != 16'hFFFF) gcnt_q[gnt_id] <= gcnt_q[gnt_id] + 16'd1;
            if (|req_valid_i && !issue && scnt_q != 16'hFFFF) scnt_q <= scnt_q + 16'd1;
        end
    end

    assign grant_cnt_o = gcnt_q;
    assign stall_cnt_o = scnt_q;
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: behavioural FP32 adder, rr-grant model and result scoreboard.
module tb_fp_add_arbiter;

    localparam int NUM_REQ    = 2;
    localparam int ADD_LAT    = 3;
    localparam int FIFO_DEPTH = 4;
    localparam int IDW        = $clog2(NUM_REQ);

    logic                  clock_i = 1'b0;
    logic                  rst_n_i;
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [32*NUM_REQ-1:0] req_a_i, req_b_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [31:0]           add_a_o, add_b_o, add_sum_i;
    logic                  res_valid_o, res_ready_i;
    logic [31:0]           res_data_o;
    logic [IDW-1:0]        res_id_o;
    logic                  flush_i, flush_done_o;
`ifdef FPA_STATS_EN
    logic [16*NUM_REQ-1:0] grant_cnt_o;
    logic [15:0]           stall_cnt_o;
`endif

    fp_add_arbiter #(.NUM_REQ(NUM_REQ), .ADD_LAT(ADD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clock_i(clock_i), .rst_n_i(rst_n_i),
        .req_valid_i(req_valid_i), .req_a_i(req_a_i), .req_b_i(req_b_i), .req_ready_o(req_ready_o),
        .add_a_o(add_a_o), .add_b_o(add_b_o), .add_sum_i(add_sum_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o), .res_id_o(res_id_o),
        .flush_i(flush_i), .flush_done_o(flush_done_o)
`ifdef FPA_STATS_EN
        , .grant_cnt_o(grant_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
    );

    always #5 clock_i = ~clock_i;

    // Positive normal operands only; truncating add is enough to give each op a distinct sum.
    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y;
        logic [7:0]  e;
        logic [24:0] mx, my, m;
        int          sh;
        if (a[30:23] >= b[30:23]) begin x = a; y = b; end else begin x = b; y = a; end
        e  = x[30:23];
        sh = int'(x[30:23]) - int'(y[30:23]);
        mx = {2'b01, x[22:0]};
        my = (sh > 24) ? 25'd0 : ({2'b01, y[22:0]} >> sh);
        m  = mx + my;
        if (m[24]) begin m = m >> 1; e = e + 8'd1; end
        return {1'b0, e, m[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        return {1'b0, 8'($urandom_range(110, 140)), 23'($urandom)};
    endfunction

    logic [31:0] s1, s2;
    always @(posedge clock_i) begin
        s1 <= fadd(add_a_o, add_b_o);
        s2 <= s1;
    end
    assign add_sum_i = s2;

    int pass_cnt = 0, chk_cnt = 0, fail_cnt = 0;
    logic [63:0] exp_q[$];
    int exp_ptr = NUM_REQ - 1;
    int mon_w;
    logic [NUM_REQ-1:0] exp_g;
    logic [63:0] mon_e;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        for (int n = 0; n < 60; n++) begin
            @(negedge clock_i);
            if (exp_q.size() == 0 && !res_valid_o) break;
        end
        check(tag, {exp_q.size() != 0, res_valid_o}, 0);
    endtask

    // Round-robin reference plus scoreboard push on accept and compare on pop.
    always @(negedge clock_i) begin
        if (!rst_n_i) begin
            exp_ptr = NUM_REQ - 1;
        end else begin
            check("onehot", $onehot0(req_ready_o), 1);
            if (|req_ready_o) begin
                mon_w = -1;
                for (int k = 1; k <= NUM_REQ; k++)
                    if (mon_w < 0 && req_valid_i[(exp_ptr + k) % NUM_REQ]) mon_w = (exp_ptr + k) % NUM_REQ;
                exp_g = '0;
                if (mon_w >= 0) exp_g[mon_w] = 1'b1;
                check("rr_grant", req_ready_o, exp_g);
                if (mon_w >= 0) begin
                    exp_ptr = mon_w;
                    exp_q.push_back({32'(mon_w), fadd(req_a_i[32*mon_w +: 32], req_b_i[32*mon_w +: 32])});
                end
            end
            if (res_valid_o && res_ready_i) begin
                check("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("result", {32'(res_id_o), res_data_o}, mon_e);
                end
            end
        end
    end

    int acc, g0, g1;
    logic rv1, rv2;

    initial begin
        rst_n_i = 1'b0; req_valid_i = 2'b01; req_a_i = '0; req_b_i = '0;
        res_ready_i = 1'b0; flush_i = 1'b0;
        repeat (2) @(posedge clock_i);
        @(negedge clock_i);
        check("rst_ready", req_ready_o, 0);
        check("rst_outs", {res_valid_o, flush_done_o, res_data_o, 32'(res_id_o)}, 0);
        check("rst_add", {add_a_o, add_b_o}, 0);
        req_valid_i = '0;
        tick();
        rst_n_i = 1'b1;
        tick();

        // single op 1.0 + 2.0
        res_ready_i = 1'b1;
        req_valid_i = 2'b01; req_a_i[31:0] = 32'h3F800000; req_b_i[31:0] = 32'h40000000;
        @(negedge clock_i);
        check("t1_ready", req_ready_o, 2'b01);
        tick();
        req_valid_i = '0;
        @(negedge clock_i);
        check("t1_add_ops", {add_a_o, add_b_o}, {32'h3F800000, 32'h40000000});
        repeat (2) tick();
        @(negedge clock_i);
        check("t1_latency_early", res_valid_o, 0);
        tick();
        @(negedge clock_i);
        check("t1_res", {res_valid_o, res_data_o, 32'(res_id_o)}, {1'b1, 32'h40400000, 32'd0});
        wait_idle("t1_idle");

        // both requesters contend
        tick();
        g0 = 0; g1 = 0;
        req_valid_i = 2'b11;
        req_a_i = {rnd_op(), rnd_op()}; req_b_i = {rnd_op(), rnd_op()};
        for (int i = 0; i < 10; i++) begin
            @(negedge clock_i);
            if (req_ready_o[0]) g0++;
            if (req_ready_o[1]) g1++;
            tick();
            req_a_i = {rnd_op(), rnd_op()}; req_b_i = {rnd_op(), rnd_op()};
        end
        req_valid_i = '0;
        check("t2_balance", (g1 - g0 == 0) || (g1 - g0 == 1), 1);
        check("t2_progress", (g0 + g1) >= 4, 1);
        wait_idle("t2_idle");

        // backpressure fills the FIFO to exactly FIFO_DEPTH accepts
        tick();
        res_ready_i = 1'b0; acc = 0;
        req_valid_i = 2'b01; req_a_i[31:0] = rnd_op(); req_b_i[31:0] = rnd_op();
        for (int i = 0; i < 12; i++) begin
            @(negedge clock_i);
            if (req_ready_o[0]) acc++;
            tick();
            req_a_i[31:0] = rnd_op(); req_b_i[31:0] = rnd_op();
        end
        check("t3_accepts", acc, FIFO_DEPTH);
        check("t3_full_ready", req_ready_o, 0);

        // pop a full FIFO, issue one op, and land it while popping again
        res_ready_i = 1'b1;
        @(negedge clock_i);
        check("t6_pop_not_credited", req_ready_o, 0);
        tick();
        res_ready_i = 1'b0;
        @(negedge clock_i);
        check("t6_credit_after_pop", req_ready_o, 2'b01);
        tick();
        @(negedge clock_i);
        check("t6_inflight_holds_credit_c", req_ready_o, 0);
        tick();
        @(negedge clock_i);
        check("t6_inflight_holds_credit_d", req_ready_o, 0);
        tick();
        res_ready_i = 1'b1;
        @(negedge clock_i);
        check("t6_push_pop_cycle", {res_valid_o, req_ready_o}, {1'b1, 2'b00});
        for (int i = 0; i < 8; i++) begin
            tick();
            req_a_i[31:0] = rnd_op(); req_b_i[31:0] = rnd_op();
        end
        req_valid_i = '0;
        wait_idle("t3_idle");

        // flush with three ops in flight
        tick();
        req_valid_i = 2'b01;
        for (int i = 0; i < 3; i++) begin
            req_a_i[31:0] = rnd_op(); req_b_i[31:0] = rnd_op();
            if (i == 2) flush_i = 1'b1;
            @(negedge clock_i);
            check("t4_issue", req_ready_o, 2'b01);
            tick();
        end
        @(negedge clock_i);
        check("t4_no_grant_drain", req_ready_o, 0);
        rv1 = res_valid_o; rv2 = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock_i);
            if (flush_done_o) break;
            rv2 = rv1; rv1 = res_valid_o;
        end
        check("t4_flush_done", flush_done_o, 1);
        check("t4_after_last_pop", {rv2, rv1}, 2'b10);
        check("t4_drained", exp_q.size(), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock_i);
            check("t4_single_pulse", {flush_done_o, req_ready_o}, 0);
        end
        @(posedge clock_i); #1;
        flush_i = 1'b0;
        @(negedge clock_i);
        check("t4_still_drain", req_ready_o, 0);
        tick();
        @(negedge clock_i);
        check("t4_resume_run", req_ready_o, 2'b01);
        tick();
        req_valid_i = '0;
        wait_idle("t4_idle");

        // reset with two ops in flight
        tick();
        req_valid_i = 2'b01;
        req_a_i[31:0] = rnd_op(); req_b_i[31:0] = rnd_op();
        tick();
        req_a_i[31:0] = rnd_op(); req_b_i[31:0] = rnd_op();
        tick();
        #2;
        rst_n_i = 1'b0;
        exp_q.delete();
        #1;
        check("t5_rst_ready", req_ready_o, 0);
        check("t5_rst_add", {add_a_o, add_b_o}, 0);
        check("t5_rst_outs", {res_valid_o, flush_done_o, res_data_o, 32'(res_id_o)}, 0);
        req_valid_i = '0;
        repeat (2) @(posedge clock_i);
        #1;
        rst_n_i = 1'b1;
        for (int i = 0; i < ADD_LAT + 3; i++) begin
            @(negedge clock_i);
            check("t5_no_stale", res_valid_o, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
